// File: rtl/hls_handshake_profiler.sv
// hls_handshake_profiler
// Multi-channel profiler for ap_ctrl_chain handshakes. For each monitored HLS
// submodule it counts completed transactions, measures latency (last/min/max,
// start cycle to done cycle inclusive) and counts output-stall cycles spent
// waiting for ap_continue. Statistics are read back through a registered
// select port with one cycle of latency.
//
// Optional feature: define PROFILER_II_EN to build the per-channel start-to-start
// interval counter (field 5, last_ii). Without it, field 5 reads 0.
//
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   ap_start/ap_ready/
//   ap_done/ap_continue     per-channel handshake taps (NUM_CH bits each)
//   finish                  sticky end-of-test; freezes statistics and FSMs
//   clr                     synchronous clear of all statistics
//   rd_en, rd_ch, rd_field  read request: channel and field select
//   rd_valid, rd_data       read response, one cycle after rd_en
//   frozen                  finish has been seen
module hls_handshake_profiler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              frozen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment shared by every statistic counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_r     [NUM_CH];
    state_t           state_nxt_s [NUM_CH];
    logic [CNT_W-1:0] lat_r       [NUM_CH];
    logic [CNT_W-1:0] cap_lat_s   [NUM_CH];
    logic [CNT_W-1:0] txn_r       [NUM_CH];
    logic [CNT_W-1:0] last_lat_r  [NUM_CH];
    logic [CNT_W-1:0] min_lat_r   [NUM_CH];
    logic [CNT_W-1:0] max_lat_r   [NUM_CH];
    logic [CNT_W-1:0] stall_r     [NUM_CH];
    logic [NUM_CH-1:0] capture_s;
    logic [NUM_CH-1:0] start_run_s;
    logic [NUM_CH-1:0] one_cycle_s;
    logic [CNT_W-1:0] rd_sel_s;
    logic             freeze_s;

    // finish freezes in its own cycle as well as every cycle after.
    assign freeze_s = finish | frozen;

    // Per-channel next-state and capture decode.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            capture_s[i]   = 1'b0;
            start_run_s[i] = 1'b0;
            one_cycle_s[i] = 1'b0;
            if (freeze_s) begin
                state_nxt_s[i] = state_r[i];
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (ap_start[i] && ap_done[i] && ap_continue[i]) begin
                            capture_s[i]   = 1'b1;
                            one_cycle_s[i] = 1'b1;
                        end else if (ap_start[i]) begin
                            state_nxt_s[i] = ST_RUN;
                            start_run_s[i] = 1'b1;
                        end else begin
                            state_nxt_s[i] = ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (ap_done[i]) begin
                            capture_s[i]   = 1'b1;
                            state_nxt_s[i] = ap_continue[i] ? ST_IDLE : ST_HOLD;
                        end else begin
                            state_nxt_s[i] = ST_RUN;
                        end
                    end
                    ST_HOLD: begin
                        if (ap_continue[i]) begin
                            state_nxt_s[i] = ST_IDLE;
                        end else begin
                            state_nxt_s[i] = ST_HOLD;
                        end
                    end
                    default: state_nxt_s[i] = ST_IDLE;
                endcase
            end
            // The done cycle counts inclusively, hence lat + 1.
            if (one_cycle_s[i]) begin
                cap_lat_s[i] = CNT_ONE;
            end else begin
                cap_lat_s[i] = sat_inc(lat_r[i]);
            end
        end
    end

    // FSM state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) state_r[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_r[i] <= state_nxt_s[i];
        end
    end

    // Latency counters: belong to the FSM, so clr leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) lat_r[i] <= '0;
        end else if (!freeze_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_run_s[i]) begin
                    lat_r[i] <= CNT_ONE;
                end else if (state_r[i] == ST_RUN) begin
                    lat_r[i] <= sat_inc(lat_r[i]);
                end else begin
                    lat_r[i] <= lat_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) lat_r[i] <= lat_r[i];
        end
    end

    // Statistics; clr takes priority over a same-cycle capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                txn_r[i]      <= '0;
                last_lat_r[i] <= '0;
                min_lat_r[i]  <= CNT_MAX;
                max_lat_r[i]  <= '0;
                stall_r[i]    <= '0;
            end
        end else if (freeze_s) begin
            for (int i = 0; i < NUM_CH; i++) txn_r[i] <= txn_r[i];
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                txn_r[i]      <= '0;
                last_lat_r[i] <= '0;
                min_lat_r[i]  <= CNT_MAX;
                max_lat_r[i]  <= '0;
                stall_r[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture_s[i]) begin
                    txn_r[i]      <= sat_inc(txn_r[i]);
                    last_lat_r[i] <= cap_lat_s[i];
                    if (cap_lat_s[i] < min_lat_r[i]) min_lat_r[i] <= cap_lat_s[i];
                    if (cap_lat_s[i] > max_lat_r[i]) max_lat_r[i] <= cap_lat_s[i];
                end
                if (state_r[i] == ST_HOLD) begin
                    stall_r[i] <= sat_inc(stall_r[i]);
                end
            end
        end
    end

`ifdef PROFILER_II_EN
    logic [CNT_W-1:0]  ii_r      [NUM_CH];
    logic [CNT_W-1:0]  last_ii_r [NUM_CH];
    logic [NUM_CH-1:0] seen_r;

    // Start-to-start interval: counter restarts at 1 on every accepted start;
    // the value reached by the next start is the interval.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ii_r[i]      <= '0;
                last_ii_r[i] <= '0;
            end
        end else if (!freeze_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_run_s[i] || one_cycle_s[i]) begin
                    ii_r[i]   <= CNT_ONE;
                    seen_r[i] <= 1'b1;
                end else begin
                    ii_r[i] <= sat_inc(ii_r[i]);
                end
                if (clr) begin
                    last_ii_r[i] <= '0;
                end else if ((start_run_s[i] || one_cycle_s[i]) && seen_r[i]) begin
                    last_ii_r[i] <= ii_r[i];
                end else begin
                    last_ii_r[i] <= last_ii_r[i];
                end
            end
        end else begin
            seen_r <= seen_r;
        end
    end
`endif

    // Read select; out-of-range channels never match and read 0.
    always_comb begin
        rd_sel_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_field)
                    3'd0:    rd_sel_s = txn_r[i];
                    3'd1:    rd_sel_s = last_lat_r[i];
                    3'd2:    rd_sel_s = min_lat_r[i];
                    3'd3:    rd_sel_s = max_lat_r[i];
                    3'd4:    rd_sel_s = stall_r[i];
`ifdef PROFILER_II_EN
                    3'd5:    rd_sel_s = last_ii_r[i];
`else
                    3'd5:    rd_sel_s = '0;
`endif
                    3'd6:    rd_sel_s = CNT_W'({ap_ready[i], state_r[i]});
                    default: rd_sel_s = '0;
                endcase
            end else begin
                rd_sel_s = rd_sel_s;
            end
        end
    end

    // Registered read port and sticky frozen flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            frozen   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_sel_s;
            end else begin
                rd_data <= rd_data;
            end
            if (finish) begin
                frozen <= 1'b1;
            end else begin
                frozen <= frozen;
            end
        end
    end

endmodule

// File: tb/tb_hls_handshake_profiler.sv
// Directed testbench for hls_handshake_profiler (NUM_CH=4, CNT_W=8, CH_W=4).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle after the rising edge that produced them.
module tb_hls_handshake_profiler;

    logic       clock;
    logic       reset;
    logic [3:0] ap_start, ap_ready, ap_done, ap_continue;
    logic       finish, clr, rd_en;
    logic [3:0] rd_ch;
    logic [2:0] rd_field;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       frozen;

    int n_checks = 0;
    int n_fail   = 0;

    hls_handshake_profiler #(.NUM_CH(4), .CNT_W(8), .CH_W(4)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish), .clr(clr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
        .rd_valid(rd_valid), .rd_data(rd_data), .frozen(frozen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] ch, input logic [2:0] field,
                      input logic [31:0] exp, input string tag);
        rd_en = 1'b1; rd_ch = ch; rd_field = field;
        tick(1);
        rd_en = 1'b0;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, {24'd0, rd_data}, exp);
    endtask

    initial begin
        reset = 1'b1; ap_start = 4'h0; ap_ready = 4'h0; ap_done = 4'h0;
        ap_continue = 4'hF; finish = 1'b0; clr = 1'b0; rd_en = 1'b0;
        rd_ch = 4'd0; rd_field = 3'd0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_valid",  {31'd0, rd_valid}, 32'd0);
        chk("rst_data",   {24'd0, rd_data},  32'd0);
        chk("rst_frozen", {31'd0, frozen},   32'd0);
        rd(4'd0, 3'd2, 32'hFF, "rst_min");
        rd(4'd0, 3'd0, 32'h00, "rst_txn");
        tick(1);
        chk("valid_drop", {31'd0, rd_valid}, 32'd0);

        // Single transaction on ch0: start cycle 0, done cycle 4 -> latency 5
        ap_start[0] = 1'b1; tick(1); ap_start[0] = 1'b0;
        tick(3);
        ap_done[0] = 1'b1; tick(1); ap_done[0] = 1'b0;
        rd(4'd0, 3'd0, 32'd1, "ch0_txn");
        rd(4'd0, 3'd1, 32'd5, "ch0_last");
        rd(4'd0, 3'd2, 32'd5, "ch0_min");
        rd(4'd0, 3'd3, 32'd5, "ch0_max");
        rd(4'd0, 3'd4, 32'd0, "ch0_stall");

        // Backpressure on ch1: done at cycle 3 with continue low for 3 cycles
        ap_start[1] = 1'b1; tick(1); ap_start[1] = 1'b0;
        tick(2);
        ap_done[1] = 1'b1; ap_continue[1] = 1'b0; tick(1);
        tick(1);
        rd(4'd1, 3'd6, 32'd2, "ch1_status_hold");
        ap_continue[1] = 1'b1; ap_done[1] = 1'b0; tick(1);
        rd(4'd1, 3'd4, 32'd3, "ch1_stall");
        rd(4'd1, 3'd1, 32'd4, "ch1_last");
        rd(4'd1, 3'd0, 32'd1, "ch1_txn");
        rd(4'd1, 3'd6, 32'd0, "ch1_status_idle");

        // Same-cycle start/done on ch2, 4 times
        ap_start[2] = 1'b1; ap_done[2] = 1'b1; tick(4);
        ap_start[2] = 1'b0; ap_done[2] = 1'b0;
        rd(4'd2, 3'd0, 32'd4, "ch2_txn");
        rd(4'd2, 3'd1, 32'd1, "ch2_last");
        rd(4'd2, 3'd2, 32'd1, "ch2_min");
        rd(4'd2, 3'd3, 32'd1, "ch2_max");

        // Saturation on ch3, then a latency-3 transaction
        ap_start[3] = 1'b1; tick(1); ap_start[3] = 1'b0;
        tick(300);
        ap_done[3] = 1'b1; tick(1); ap_done[3] = 1'b0;
        rd(4'd3, 3'd1, 32'd255, "ch3_sat_last");
        ap_start[3] = 1'b1; tick(1); ap_start[3] = 1'b0;
        tick(1);
        ap_done[3] = 1'b1; tick(1); ap_done[3] = 1'b0;
        rd(4'd3, 3'd2, 32'd3, "ch3_min");
        rd(4'd3, 3'd3, 32'd255, "ch3_max");
        rd(4'd3, 3'd0, 32'd2, "ch3_txn");

        // Start-to-start interval on ch0: starts at cycles 0 and 7
        ap_start[0] = 1'b1; tick(1); ap_start[0] = 1'b0;
        tick(5);
        ap_done[0] = 1'b1; tick(1); ap_done[0] = 1'b0;
        ap_start[0] = 1'b1; tick(1); ap_start[0] = 1'b0;
        ap_done[0] = 1'b1; tick(1); ap_done[0] = 1'b0;
`ifdef PROFILER_II_EN
        rd(4'd0, 3'd5, 32'd7, "ch0_ii");
`else
        rd(4'd0, 3'd5, 32'd0, "ch0_ii");
`endif
        rd(4'd0, 3'd1, 32'd2, "ch0_last2");
        rd(4'd0, 3'd3, 32'd7, "ch0_max2");
        rd(4'd0, 3'd0, 32'd3, "ch0_txn3");
        rd(4'd4, 3'd0, 32'd0, "oor_ch4");
        rd(4'd15, 3'd3, 32'd0, "oor_ch15");
        rd(4'd0, 3'd7, 32'd0, "field7");

        // clr coincides with a ch2 capture while ch0 is in RUN
        ap_start[0] = 1'b1; tick(1); ap_start[0] = 1'b0;
        clr = 1'b1; ap_start[2] = 1'b1; ap_done[2] = 1'b1; tick(1);
        clr = 1'b0; ap_start[2] = 1'b0; ap_done[2] = 1'b0;
        ap_done[0] = 1'b1; tick(1); ap_done[0] = 1'b0;
        rd(4'd2, 3'd0, 32'd0,  "clr_ch2_txn");
        rd(4'd2, 3'd1, 32'd0,  "clr_ch2_last");
        rd(4'd2, 3'd2, 32'hFF, "clr_ch2_min");
        rd(4'd3, 3'd3, 32'd0,  "clr_ch3_max");
        rd(4'd1, 3'd4, 32'd0,  "clr_ch1_stall");
        rd(4'd0, 3'd0, 32'd1,  "clr_ch0_txn");
        rd(4'd0, 3'd1, 32'd3,  "clr_ch0_last");

        // finish freezes statistics, clr and FSMs
        finish = 1'b1; tick(1); finish = 1'b0;
        chk("frozen_set", {31'd0, frozen}, 32'd1);
        ap_start[2] = 1'b1; ap_done[2] = 1'b1; tick(2);
        ap_start[2] = 1'b0; ap_done[2] = 1'b0;
        clr = 1'b1; tick(1); clr = 1'b0;
        ap_start[1] = 1'b1; tick(1); ap_start[1] = 1'b0;
        rd(4'd2, 3'd0, 32'd0, "frz_ch2_txn");
        rd(4'd0, 3'd0, 32'd1, "frz_ch0_txn");
        rd(4'd0, 3'd1, 32'd3, "frz_ch0_last");
        rd(4'd1, 3'd6, 32'd0, "frz_ch1_status");
        chk("frozen_hold", {31'd0, frozen}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
